sram_ctrl: RTL and testbench

Synchronous single-port SRAM controller. Accepts read/write requests on a valid/ready host port and generates chip-enable, write-enable and output-enable strobes, the address, and the bidirectional data bus for an external synchronous SRAM. It is the initiator for `sram_model` and sits between the system bus logic and the SRAM pins. Every SRAM-side output is a flop, so strobes are glitch-free and bus contention is impossible.

---
 rtl/sram_ctrl_pkg.sv | 24 ++
 rtl/sram_ctrl_if.sv | 30 +++
 rtl/sram_io_buf.sv | 14 +
 rtl/sram_ctrl.sv | 102 ++++++++++
 tb/tb_sram_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the synchronous SRAM controller.
package sram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Legal (ce, we, oe) strobe combinations.
  localparam logic [2:0] STB_OFF = 3'b000;
  localparam logic [2:0] STB_WR  = 3'b110;
  localparam logic [2:0] STB_RD  = 3'b101;

  typedef struct packed {
    state_t state;
    logic   bus_oe;
  } dbg_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// Host request/response port of the SRAM controller.
interface sram_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  // Handshake: a request transfers at a rising edge where req_valid and
  // req_ready are both 1; the host holds its request stable until then.
  // rsp_valid is a one-cycle pulse with no back-pressure.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_io_buf.sv
// Tristate pad buffer for the SRAM data bus; all bus resolution lives here.
module sram_io_buf #(
  parameter int WIDTH = 16
) (
  input  logic             i_oe,
  input  logic [WIDTH-1:0] i_dout,
  output logic [WIDTH-1:0] o_din,
  inout  wire  [WIDTH-1:0] io_pad
);

  assign io_pad = i_oe ? i_dout : {WIDTH{1'bz}};
  assign o_din  = io_pad;

endmodule

// File: rtl/sram_ctrl.sv
// Single-port synchronous SRAM controller: IDLE -> WR/RD -> RESP -> IDLE,
// with every SRAM-side output taken straight from a flop.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_ctrl_if.slave            host,
  inout  wire  [DATA_WIDTH-1:0] sram_data_io,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic                  sram_ce_o,
  output logic                  sram_we_o,
  output logic                  sram_oe_o,
  output dbg_t                  o_dbg
);

  state_t                r_state;
  logic                  r_ce;
  logic                  r_we;
  logic                  r_oe;
  logic                  r_drv;
  logic                  r_rsp_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state              <= ST_IDLE;
      {r_ce, r_we, r_oe}   <= STB_OFF;
      r_drv                <= 1'b0;
      r_rsp_valid          <= 1'b0;
      r_addr               <= '0;
      r_wdata              <= '0;
      r_rdata              <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (host.req_valid) begin
            r_addr  <= host.req_addr;
            r_wdata <= host.req_wdata;
            if (host.req_we) begin
              r_state            <= ST_WR;
              {r_ce, r_we, r_oe} <= STB_WR;
              r_drv              <= 1'b1;
            end else begin
              r_state            <= ST_RD;
              {r_ce, r_we, r_oe} <= STB_RD;
            end
          end
        end
        ST_WR: begin
          r_state            <= ST_RESP;
          {r_ce, r_we, r_oe} <= STB_OFF;
          r_drv              <= 1'b0;
          r_rsp_valid        <= 1'b1;
        end
        ST_RD: begin
          // The SRAM drives the bus throughout RD; sample it as RD ends.
          r_state            <= ST_RESP;
          {r_ce, r_we, r_oe} <= STB_OFF;
          r_rdata            <= w_din;
          r_rsp_valid        <= 1'b1;
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state            <= ST_IDLE;
          {r_ce, r_we, r_oe} <= STB_OFF;
          r_drv              <= 1'b0;
        end
      endcase
    end
  end

  sram_io_buf #(.WIDTH(DATA_WIDTH)) u_io_buf (
    .i_oe   (r_drv),
    .i_dout (r_wdata),
    .o_din  (w_din),
    .io_pad (sram_data_io)
  );

  // Gated by rst_n so the host sees "not ready" for as long as reset is held.
  assign host.req_ready = (r_state == ST_IDLE) && rst_n;
  assign host.rsp_valid = r_rsp_valid;
  assign host.rsp_rdata = r_rdata;

  assign sram_addr_o = r_addr;
  assign sram_ce_o   = r_ce;
  assign sram_we_o   = r_we;
  assign sram_oe_o   = r_oe;

  assign o_dbg.state  = r_state;
  assign o_dbg.bus_oe = r_drv;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: behavioural SRAM, reference memory,
// expected-read queue and per-cycle protocol checks.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk;
  logic          rst_n;
  wire  [DW-1:0] sram_data_io;
  logic [AW-1:0] sram_addr_o;
  logic          sram_ce_o;
  logic          sram_we_o;
  logic          sram_oe_o;
  dbg_t          o_dbg;

  sram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host         (bus),
    .sram_data_io (sram_data_io),
    .sram_addr_o  (sram_addr_o),
    .sram_ce_o    (sram_ce_o),
    .sram_we_o    (sram_we_o),
    .sram_oe_o    (sram_oe_o),
    .o_dbg        (o_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural synchronous SRAM
  logic [DW-1:0] sram_mem [256];
  assign sram_data_io = (sram_ce_o && sram_oe_o && !sram_we_o) ? sram_mem[sram_addr_o] : {DW{1'bz}};
  always @(posedge clk) begin
    if (sram_ce_o && sram_we_o) sram_mem[sram_addr_o] <= sram_data_io;
  end

  // scoreboard state
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] ref_mem [256];
  bit            ref_ok  [256];
  logic [AW-1:0] written_q [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_rd = '0;
  bit            last_hold = 1'b0;
  time           t_prev_acc = 0;
  bit            prev_rv = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // per-cycle protocol checks
  always @(negedge clk) begin
    if (rst_n) begin
      check_val("strobe_legal",
                ({sram_ce_o, sram_we_o, sram_oe_o} inside {3'b000, 3'b110, 3'b101}) ? 32'd1 : 32'd0, 32'd1);
      check_val("bus_contention", {31'd0, sram_oe_o && o_dbg.bus_oe}, 32'd0);
      check_val("drive_only_wr", {31'd0, o_dbg.bus_oe}, {31'd0, sram_we_o});
      check_val("rsp_double", {31'd0, prev_rv && bus.rsp_valid}, 32'd0);
    end
    prev_rv = rst_n ? bus.rsp_valid : 1'b0;
  end

  // driver: one request, checked through its whole lifetime; returns at the
  // negedge where the controller is ready again
  task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit hold);
    int            n;
    time           t_acc;
    logic [DW-1:0] exp;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check_val("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      last_hold = 1'b0;
      return;
    end
    @(posedge clk);
    t_acc = $time;
    if (last_hold) check_val("accept_gap", 32'(t_acc - t_prev_acc), 32'd30);
    t_prev_acc = t_acc;
    last_hold  = hold;
    if (we) begin
      ref_mem[a] = d;
      if (!ref_ok[a]) written_q.push_back(a);
      ref_ok[a] = 1'b1;
    end else begin
      exp_q.push_back(ref_mem[a]);
    end
    #1;
    if (hold) begin
      bus.req_we    = 1'($urandom_range(0, 1));
      bus.req_addr  = AW'($urandom);
      bus.req_wdata = DW'($urandom);
    end else begin
      bus.req_valid = 1'b0;
    end
    @(negedge clk);
    check_val("busy_strobes", {29'd0, sram_ce_o, sram_we_o, sram_oe_o}, we ? 32'd6 : 32'd5);
    check_val("busy_addr", {24'd0, sram_addr_o}, {24'd0, a});
    check_val("busy_ready", {31'd0, bus.req_ready}, 32'd0);
    check_val("busy_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    check_val("busy_state", {30'd0, o_dbg.state}, we ? 32'(ST_WR) : 32'(ST_RD));
    if (we) check_val("wr_bus", {16'd0, sram_data_io}, {16'd0, d});
    @(negedge clk);
    check_val("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check_val("rsp_strobes", {29'd0, sram_ce_o, sram_we_o, sram_oe_o}, 32'd0);
    check_val("rsp_ready", {31'd0, bus.req_ready}, 32'd0);
    check_val("rsp_bus_off", {31'd0, o_dbg.bus_oe}, 32'd0);
    if (!we) begin
      if (exp_q.size() == 0) begin
        check_val("exp_q_empty", 32'd0, 32'd1);
      end else begin
        exp = exp_q.pop_front();
        check_val("rd_data", {16'd0, bus.rsp_rdata}, {16'd0, exp});
        last_rd = exp;
      end
    end else begin
      check_val("rdata_hold", {16'd0, bus.rsp_rdata}, {16'd0, last_rd});
    end
    @(negedge clk);
    check_val("ready_again", {31'd0, bus.req_ready}, 32'd1);
    check_val("rsp_pulse_end", {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit            we;
    logic [AW-1:0] a;
    for (int i = 0; i < 256; i++) ref_ok[i] = 1'b0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #3;
    check_val("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    check_val("rst_strobes", {29'd0, sram_ce_o, sram_we_o, sram_oe_o}, 32'd0);
    check_val("rst_addr", {24'd0, sram_addr_o}, 32'd0);
    check_val("rst_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    check_val("rst_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);

    // basic write then read
    do_req(1'b1, 8'h10, 16'hA5A5, 1'b0);
    do_req(1'b0, 8'h10, 16'h0000, 1'b0);

    // back-to-back with req_valid held high throughout
    for (int i = 0; i < 4; i++) do_req(1'b1, AW'(i), DW'(16'h1111 * (i + 1)), 1'b1);
    for (int i = 0; i < 4; i++) do_req(1'b0, AW'(i), 16'h0000, i < 3);

    // address extremes
    do_req(1'b1, 8'hFF, 16'hFFFF, 1'b0);
    do_req(1'b1, 8'h00, 16'h0001, 1'b0);
    do_req(1'b0, 8'hFF, 16'h0000, 1'b0);
    do_req(1'b0, 8'h00, 16'h0000, 1'b0);

    // reset in the middle of a write must not commit it
    do_req(1'b1, 8'h20, 16'h1234, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 8'h20;
    bus.req_wdata = 16'hBEEF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check_val("midwr_strobes", {29'd0, sram_ce_o, sram_we_o, sram_oe_o}, 32'd6);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("rstwr_strobes", {29'd0, sram_ce_o, sram_we_o, sram_oe_o}, 32'd0);
    check_val("rstwr_bus_off", {31'd0, o_dbg.bus_oe}, 32'd0);
    check_val("rstwr_addr", {24'd0, sram_addr_o}, 32'd0);
    check_val("rstwr_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
    check_val("rstwr_ready", {31'd0, bus.req_ready}, 32'd0);
    check_val("rstwr_state", {30'd0, o_dbg.state}, 32'(ST_IDLE));
    #1;
    rst_n     = 1'b1;
    last_rd   = '0;
    last_hold = 1'b0;
    @(negedge clk);
    check_val("rstwr_ready_back", {31'd0, bus.req_ready}, 32'd1);
    do_req(1'b0, 8'h20, 16'h0000, 1'b0);

    // randomized traffic against the reference memory
    for (int k = 0; k < 40; k++) begin
      we = (written_q.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (we) a = AW'($urandom_range(0, 255));
      else    a = written_q[$urandom_range(0, written_q.size() - 1)];
      do_req(we, a, DW'($urandom), (k < 39) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
